// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle CPU sequencer: steps each instruction through fetch, decode,
// execute, optional memory access and writeback, with halt and retire limits.
module cpu_seq_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR    = 32'h0000_006F,
    parameter logic [31:0] TIMEOUT_INSTR = 32'd80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        step_mode,
    input  logic        step_req,
    input  logic [31:0] pc_out,
    input  logic [31:0] instr,
    input  logic        is_branch_taken,
    input  logic [31:0] branch_target,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic [31:0] next_pc,
    output logic        ir_load,
    output logic        mem_req,
    output logic        mem_we,
    output logic        rf_we,
    output logic [2:0]  state,
    output logic        halted,
    output logic        timeout,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        timeout_q, timeout_d;
    logic [31:0] retired_inc;

    assign retired_inc = (retired_q == 32'hFFFF_FFFF) ? retired_q : retired_q + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            retired_q <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        timeout_d = timeout_q;
        pc_write  = 1'b0;
        next_pc   = RESET_PC;
        ir_load   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        rf_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((start && !step_mode) || (step_req && step_mode))
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_load = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = (instr == HALT_INSTR) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_d = (mem_read || mem_write) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = mem_write;
                if (mem_ready)
                    state_d = S_WB;
            end
            S_WB: begin
                pc_write  = 1'b1;
                rf_we     = reg_write;
                retired_d = retired_inc;
                // Redirect targets are forced word-aligned; sequential PC wraps naturally.
                next_pc   = is_branch_taken ? {branch_target[31:2], 2'b00} : pc_out + 32'd4;
                if ((TIMEOUT_INSTR != 32'd0) && (retired_inc == TIMEOUT_INSTR)) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else if (step_mode) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign timeout = timeout_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Randomized self-checking bench for cpu_seq_ctrl against an instruction-level model.
module tb_cpu_seq_ctrl;

    localparam logic [31:0] RESET_PC   = 32'h0000_0040;
    localparam logic [31:0] HALT_INSTR = 32'h0000_006F;
    localparam int          LIMIT      = 80;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step_req = 1'b0;
    logic [31:0] pc_out = '0;
    logic [31:0] instr = '0;
    logic        is_branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        reg_write = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write;
    logic [31:0] next_pc;
    logic        ir_load;
    logic        mem_req;
    logic        mem_we;
    logic        rf_we;
    logic [2:0]  state;
    logic        halted;
    logic        timeout;
    logic [31:0] retired;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_retired;
    logic        exp_timeout;
    logic [2:0]  exp_state;

    cpu_seq_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode),
        .step_req(step_req), .pc_out(pc_out), .instr(instr),
        .is_branch_taken(is_branch_taken), .branch_target(branch_target),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_ready(mem_ready), .pc_write(pc_write), .next_pc(next_pc),
        .ir_load(ir_load), .mem_req(mem_req), .mem_we(mem_we), .rf_we(rf_we),
        .state(state), .halted(halted), .timeout(timeout), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; step_req = 1'b0; mem_ready = 1'b0;
        tick();
        reset = 1'b0;
        exp_retired = 32'd0; exp_timeout = 1'b0; exp_state = 3'd0;
        check_eq("rst_state", {29'd0, state}, 32'd0);
        check_eq("rst_retired", retired, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
        check_eq("rst_strobes", {27'd0, pc_write, ir_load, mem_req, mem_we, rf_we}, 32'd0);
        check_eq("rst_next_pc", next_pc, RESET_PC);
    endtask

    task automatic kick();
        if (step_mode) step_req = 1'b1;
        else           start = 1'b1;
        tick();
        start = 1'b0; step_req = 1'b0;
        exp_state = 3'd1;
    endtask

    // Runs one instruction starting in FETCH; the cycle-by-cycle shape is derived
    // from the instruction class and the number of memory wait cycles.
    task automatic do_instr(input logic [31:0] ins, input logic mr, input logic mw,
                            input logic rw, input logic br, input logic [31:0] tgt,
                            input logic [31:0] pc, input int waits);
        logic [31:0] exp_npc;
        instr = ins; mem_read = mr; mem_write = mw; reg_write = rw;
        is_branch_taken = br; branch_target = tgt; pc_out = pc; mem_ready = 1'b0;
        #1;
        check_eq("fetch_state", {29'd0, state}, 32'd1);
        check_eq("fetch_irload", {31'd0, ir_load}, 32'd1);
        check_eq("fetch_pcwrite", {31'd0, pc_write}, 32'd0);
        tick();
        check_eq("decode_state", {29'd0, state}, 32'd2);
        check_eq("decode_next_pc", next_pc, RESET_PC);
        check_eq("decode_irload", {31'd0, ir_load}, 32'd0);
        tick();
        if (ins == HALT_INSTR) begin
            exp_state = 3'd6;
            check_eq("halt_state", {29'd0, state}, 32'd6);
            check_eq("halt_flag", {31'd0, halted}, 32'd1);
            check_eq("halt_strobes", {27'd0, pc_write, ir_load, mem_req, mem_we, rf_we}, 32'd0);
            check_eq("halt_retired", retired, exp_retired);
            return;
        end
        check_eq("exec_state", {29'd0, state}, 32'd3);
        if (mr || mw) begin
            for (int k = 0; k <= waits; k++) begin
                tick();
                mem_ready = (k == waits);
                #1;
                check_eq("mem_state", {29'd0, state}, 32'd4);
                check_eq("mem_req", {31'd0, mem_req}, 32'd1);
                check_eq("mem_we", {31'd0, mem_we}, {31'd0, mw});
            end
        end
        tick();
        mem_ready = 1'b0;
        exp_npc = br ? (tgt & 32'hFFFF_FFFC) : pc + 32'd4;
        check_eq("wb_state", {29'd0, state}, 32'd5);
        check_eq("wb_pcwrite", {31'd0, pc_write}, 32'd1);
        check_eq("wb_rfwe", {31'd0, rf_we}, {31'd0, rw});
        check_eq("wb_next_pc", next_pc, exp_npc);
        if (exp_retired != 32'hFFFF_FFFF) exp_retired = exp_retired + 32'd1;
        if (exp_retired == LIMIT) begin
            exp_state = 3'd6; exp_timeout = 1'b1;
        end else begin
            exp_state = step_mode ? 3'd0 : 3'd1;
        end
        tick();
        check_eq("post_wb_state", {29'd0, state}, {29'd0, exp_state});
        check_eq("post_wb_retired", retired, exp_retired);
        check_eq("post_wb_timeout", {31'd0, timeout}, {31'd0, exp_timeout});
        check_eq("post_wb_halted", {31'd0, halted}, {31'd0, (exp_state == 3'd6)});
    endtask

    task automatic rand_instr();
        logic [31:0] ins;
        logic        mr, mw;
        ins = $urandom;
        if (ins == HALT_INSTR) ins = ins ^ 32'd1;
        mr = 1'($urandom_range(0, 1));
        mw = 1'($urandom_range(0, 1));
        do_instr(ins, mr, mw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, int'($urandom_range(0, 3)));
    endtask

    initial begin
        do_reset();

        // Basic run: ADDI, store with waits, taken branch, then halt instruction.
        kick();
        do_instr(32'h0010_0093, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_0100, 0);
        do_instr(32'h00A1_2023, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_0104, 3);
        do_instr(32'h0000_0463, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0123, 32'h0000_0108, 0);
        do_instr(HALT_INSTR, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_010C, 0);
        check_eq("halt_after3_retired", retired, 32'd3);
        start = 1'b1; step_req = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        start = 1'b0; step_req = 1'b0;
        check_eq("halt_sticky", {29'd0, state}, 32'd6);
        check_eq("halt_sticky_strobes", {27'd0, pc_write, ir_load, mem_req, mem_we, rf_we}, 32'd0);
        do_reset();

        // PC wrap, then reset abandoning a stalled memory access.
        kick();
        do_instr(32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFC, 0);
        instr = 32'h0000_2083; mem_read = 1'b1; mem_write = 1'b0; mem_ready = 1'b0;
        tick(); tick(); tick();
        check_eq("stall_mem_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midmem_rst_state", {29'd0, state}, 32'd0);
        check_eq("midmem_rst_memreq", {31'd0, mem_req}, 32'd0);
        check_eq("midmem_rst_retired", retired, 32'd0);
        do_reset();

        // Random free-running program until the retire limit halts it.
        kick();
        for (int n = 0; n < 200 && exp_state == 3'd1; n++) rand_instr();
        check_eq("limit_state", {29'd0, state}, 32'd6);
        check_eq("limit_retired", retired, LIMIT);
        check_eq("limit_timeout", {31'd0, timeout}, 32'd1);
        do_reset();

        // Single-step: start ignored, each step_req retires exactly one instruction.
        step_mode = 1'b1;
        start = 1'b1;
        tick(); tick();
        start = 1'b0;
        check_eq("step_start_ignored", {29'd0, state}, 32'd0);
        for (int s = 0; s < 2; s++) begin
            kick();
            rand_instr();
            tick(); tick();
            check_eq("step_idle", {29'd0, state}, 32'd0);
        end
        check_eq("step_retired", retired, 32'd2);
        step_mode = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
